// File: rtl/arm_pkg.sv
// Shared types for the decode/execute boundary.
// Condition codes, NZCV bit positions, ALU ops, execute bundle.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_ADC = 3'b100;

  typedef struct packed {
    logic       valid;
    cond_t      cond;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       no_write;
    logic       swap;
    logic       inv;
    logic       base_reg_write;
    logic [1:0] flag_w;
    logic [1:0] result_src;
    logic [2:0] alu_ctl;
  } id_ex_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluation against NZCV.
// NV is reserved and never executes.
module cond_check
  import arm_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c && !z;
      LS: cond_ex = !c || z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z && (n == v);
      LE: cond_ex = z || (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Decode-to-execute register with NZCV flags and condition gating.
// Side effects of the execute instruction are suppressed on stall or failed cond.
module cond_exec_stage
  import arm_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        d_cond,
  input  logic              d_pcs,
  input  logic              d_reg_w,
  input  logic              d_mem_w,
  input  logic              d_mem_to_reg,
  input  logic              d_alu_src,
  input  logic              d_no_write,
  input  logic              d_swap,
  input  logic              d_inv,
  input  logic              d_base_reg_write,
  input  logic [1:0]        d_flag_w,
  input  logic [1:0]        d_result_src,
  input  logic [2:0]        d_alu_ctl,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              e_mem_to_reg,
  output logic              e_alu_src,
  output logic              e_swap,
  output logic              e_inv,
  output logic [1:0]        e_result_src,
  output logic [2:0]        e_alu_ctl,
  output logic              cond_ex,
  output logic              pcs_src,
  output logic              reg_write,
  output logic              mem_write,
  output logic              base_reg_write,
  output logic              carry_in,
  output logic [FLAG_W-1:0] flags
);

  id_ex_t d_word;
  id_ex_t ex;
  logic   go;

  always_comb begin
    d_word                = '0;
    d_word.valid          = d_valid;
    d_word.cond           = cond_t'(d_cond);
    d_word.pcs            = d_pcs;
    d_word.reg_w          = d_reg_w;
    d_word.mem_w          = d_mem_w;
    d_word.mem_to_reg     = d_mem_to_reg;
    d_word.alu_src        = d_alu_src;
    d_word.no_write       = d_no_write;
    d_word.swap           = d_swap;
    d_word.inv            = d_inv;
    d_word.base_reg_write = d_base_reg_write;
    d_word.flag_w         = d_flag_w;
    d_word.result_src     = d_result_src;
    d_word.alu_ctl        = d_alu_ctl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex <= '0;
    end else if (flush) begin
      ex      <= '0;
      ex.cond <= AL;
    end else if (!stall) begin
      ex <= d_word;
    end
  end

  cond_check u_cond_check (
    .cond    (ex.cond),
    .flags   (flags[3:0]),
    .cond_ex (cond_ex)
  );

  assign go = ex.valid && cond_ex && !stall;

  // Flags are written only by an executing instruction; masks pick halves.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (go) begin
      if (ex.flag_w[1]) begin
        flags[N_BIT] <= alu_flags[N_BIT];
        flags[Z_BIT] <= alu_flags[Z_BIT];
      end
      if (ex.flag_w[0]) begin
        flags[C_BIT] <= alu_flags[C_BIT];
        flags[V_BIT] <= alu_flags[V_BIT];
      end
    end
  end

  assign pcs_src        = go && ex.pcs;
  assign reg_write      = go && ex.reg_w && !ex.no_write;
  assign mem_write      = go && ex.mem_w;
  assign base_reg_write = go && ex.base_reg_write;
  assign carry_in       = flags[C_BIT];

  assign e_mem_to_reg = ex.mem_to_reg;
  assign e_alu_src    = ex.alu_src;
  assign e_swap       = ex.swap;
  assign e_inv        = ex.inv;
  assign e_result_src = ex.result_src;
  assign e_alu_ctl    = ex.alu_ctl;

endmodule
